// File: rtl/a2d_pkg.sv
// Shared definitions for the A2D interface: FSM states, SPI timing constants
// and the ADC command format.
package a2d_pkg;

    typedef enum logic [2:0] {IDLE, TXN1, GAP, TXN2, DONE} state_t;

    localparam int SCLK_DIV  = 32;
    localparam int PORCH     = 8;
    localparam int GAP_CLKS  = 32;
    localparam int XFER_BITS = 16;

    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam int CNT_W = $clog2(XFER_BITS) + 1;
    localparam int GAP_W = $clog2(GAP_CLKS);

    // Command word is {2'b00, channel, 11'h000}
    localparam logic [XFER_BITS-1:0] CMD_FMT  = 16'h0000;
    localparam int                   CHNL_LSB = 11;

    function automatic logic [XFER_BITS-1:0] build_cmd(input logic [2:0] chnnl);
        build_cmd = CMD_FMT | ({13'd0, chnnl} << CHNL_LSB);
    endfunction

endpackage

// File: rtl/a2d_intf_spi_mstr16.sv
// 16-bit SPI master (SCLK idles high): 8-clk porches, clk/32 SCLK, MOSI shifted
// one clk after each SCLK fall, MISO sampled two clk after each SCLK rise.
module spi_mstr16
    import a2d_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wrt,
    input  logic [XFER_BITS-1:0] cmd,
    input  logic                 MISO,
    output logic                 done,
    output logic [XFER_BITS-1:0] rd_data,
    output logic                 SS_n,
    output logic                 SCLK,
    output logic                 MOSI
);

    // Divider starts PORCH counts before wrap so the first SCLK fall lands
    // after the front porch; the last high phase plus PORCH forms the back porch.
    localparam logic [DIV_W-1:0] DIV_START = DIV_W'(SCLK_DIV - PORCH);
    localparam logic [DIV_W-1:0] DIV_RISE  = DIV_W'(SCLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_SMPL  = DIV_W'(SCLK_DIV / 2 + 1);
    localparam logic [DIV_W-1:0] DIV_END   = DIV_W'(PORCH - 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(XFER_BITS);

    logic                 active;
    logic [DIV_W-1:0]     div;
    logic [CNT_W-1:0]     bit_cnt;
    logic [XFER_BITS-1:0] tx_shft;
    logic [XFER_BITS-1:0] rx_shft;
    logic                 all_bits;

    assign all_bits = (bit_cnt == LAST_BIT);
    assign done     = active && all_bits && (div == DIV_END);
    assign SS_n     = ~active;
    assign SCLK     = ~active | all_bits | div[DIV_W-1];
    assign MOSI     = tx_shft[XFER_BITS-1];
    assign rd_data  = rx_shft;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            div     <= '0;
            bit_cnt <= '0;
            tx_shft <= '0;
            rx_shft <= '0;
        end else if (wrt) begin
            active  <= 1'b1;
            div     <= DIV_START;
            bit_cnt <= '0;
            tx_shft <= cmd;
        end else if (done) begin
            active  <= 1'b0;
            div     <= '0;
            bit_cnt <= '0;
        end else if (active) begin
            div <= div + 1'b1;
            if (!all_bits && div == DIV_RISE)
                bit_cnt <= bit_cnt + 1'b1;
            // MSB is already on MOSI before the first fall, so skip that shift
            if (div == '0 && bit_cnt != '0 && !all_bits)
                tx_shft <= {tx_shft[XFER_BITS-2:0], 1'b0};
            if (div == DIV_SMPL && bit_cnt != '0)
                rx_shft <= {rx_shft[XFER_BITS-2:0], MISO};
        end
    end

endmodule

// File: rtl/a2d_intf.sv
// A2D converter interface: two SPI transactions per conversion, result of the
// second one presented on res. Define A2D_BUSY_ERR_EN to add the cnv_err output.
module a2d_intf
    import a2d_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
`ifdef A2D_BUSY_ERR_EN
    ,
    output logic        cnv_err
`endif
);

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

    state_t               state, nxt_state;
    logic [GAP_W-1:0]     gap_cnt;
    logic [2:0]           chnnl_reg;
    logic                 accept;
    logic                 wrt;
    logic                 spi_done;
    logic [XFER_BITS-1:0] cmd;
    logic [XFER_BITS-1:0] rd_data;
    logic [3:0]           rd_unused;

    assign rd_unused = rd_data[15:12];
    assign cmd       = build_cmd(accept ? chnnl : chnnl_reg);
    assign cnv_cmplt = (state == DONE);

    spi_mstr16 u_spi (
        .clk     (clk),
        .rst     (rst),
        .wrt     (wrt),
        .cmd     (cmd),
        .MISO    (MISO),
        .done    (spi_done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt_state;
    end

    // NOTE: every output of this block is given a default first, so no path
    // can leave one unassigned and infer a latch.
    always_comb begin
        nxt_state = state;
        accept    = 1'b0;
        wrt       = 1'b0;
        case (state)
            IDLE, DONE: if (strt_cnv) begin
                accept    = 1'b1;
                wrt       = 1'b1;
                nxt_state = TXN1;
            end
            TXN1: if (spi_done) nxt_state = GAP;
            GAP: if (gap_cnt == GAP_LAST) begin
                wrt       = 1'b1;
                nxt_state = TXN2;
            end
            TXN2: if (spi_done) nxt_state = DONE;
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt   <= '0;
            chnnl_reg <= '0;
            res       <= '0;
        end else begin
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (accept)
                chnnl_reg <= chnnl;
            if (state == TXN2 && spi_done)
                res <= rd_data[11:0];
        end
    end

`ifdef A2D_BUSY_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnv_err <= 1'b0;
        else if (accept)
            cnv_err <= 1'b0;
        else if (strt_cnv && (state == TXN1 || state == GAP || state == TXN2))
            cnv_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_a2d_intf.sv
// Self-checking bench for a2d_intf: ADC slave model, MOSI/SCLK/SS_n monitor,
// and a result scoreboard checked when cnv_cmplt rises.
module tb_a2d_intf;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        strt_cnv = 1'b0;
    logic [2:0]  chnnl    = 3'd0;
    logic        MISO     = 1'b0;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
`ifdef A2D_BUSY_ERR_EN
    logic        cnv_err;
`endif

    a2d_intf dut (
        .clk       (clk),
        .rst       (rst),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO)
`ifdef A2D_BUSY_ERR_EN
        ,
        .cnv_err   (cnv_err)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] exp_q[$];
    logic [15:0] mosi_q[$];

    int          fall_cnt  = 0;
    int          gap_run   = 0;
    int          last_gap  = 0;
    int          txn_idx   = 0;
    logic        prev_ss   = 1'b1;
    logic        prev_sclk = 1'b1;
    logic [15:0] adc_word  = 16'h0000;
    logic [15:0] mosi_sh   = 16'h0000;
    logic [11:0] adc_val   = 12'h000;

    int unsigned acc_cyc   = 0;
    int          fall_base = 0;
    int          mosi_base = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ADC model and bus monitor; odd transactions return junk that must be discarded
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            txn_idx   = 0;
            prev_ss   = 1'b1;
            prev_sclk = 1'b1;
            MISO      = 1'b0;
        end else begin
            if (prev_ss && !SS_n) begin
                txn_idx++;
                adc_word = (txn_idx % 2 == 1) ? 16'hC3A5 : {4'h0, adc_val};
                mosi_sh  = 16'h0000;
                last_gap = gap_run;
            end
            if (!prev_ss && SS_n) begin
                mosi_q.push_back(mosi_sh);
                gap_run = 1;
            end else if (SS_n) begin
                gap_run++;
            end
            if (!SS_n && prev_sclk && !SCLK) begin
                MISO     = adc_word[15];
                adc_word = {adc_word[14:0], 1'b0};
                fall_cnt++;
            end
            if (!SS_n && !prev_sclk && SCLK)
                mosi_sh = {mosi_sh[14:0], MOSI};
            prev_ss   = SS_n;
            prev_sclk = SCLK;
        end
    end

    task automatic start_conv(input logic [2:0] ch, input logic [11:0] val);
        @(negedge clk);
        chnnl     = ch;
        adc_val   = val;
        strt_cnv  = 1'b1;
        exp_q.push_back(val);
        fall_base = fall_cnt;
        mosi_base = mosi_q.size();
        acc_cyc   = cyc + 1;
        @(negedge clk);
        strt_cnv  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        logic [11:0] exp;
        while (cnv_cmplt !== 1'b1 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        if (cnv_cmplt !== 1'b1 || exp_q.size() == 0) begin
            check({tag, "_timeout"}, 32'(cnv_cmplt), 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_res"}, 32'(res), 32'(exp));
            check({tag, "_lat"}, cyc - acc_cyc, 32'd1088);
        end
        @(negedge clk);
    endtask

    task automatic check_mosi(input string tag, input logic [15:0] w);
        check({tag, "_mosi_n"}, 32'(mosi_q.size() - mosi_base), 32'd2);
        for (int i = 0; i < 2; i++)
            if (mosi_base + i < mosi_q.size())
                check($sformatf("%s_mosi%0d", tag, i), 32'(mosi_q[mosi_base + i]), 32'(w));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ss_n", 32'(SS_n), 32'd1);
        check("rst_sclk", 32'(SCLK), 32'd1);
        check("rst_mosi", 32'(MOSI), 32'd0);
        check("rst_cmplt", 32'(cnv_cmplt), 32'd0);
        check("rst_res", 32'(res), 32'd0);
        rst = 1'b0;

        // Scenario 1: channel 5
        start_conv(3'd5, 12'hA5C);
        wait_done("s1");
        check_mosi("s1", 16'h2800);

        // Scenario 2: channel 0, all-ones result, SCLK and gap timing
        start_conv(3'd0, 12'hFFF);
        wait_done("s2");
        check("s2_falls", 32'(fall_cnt - fall_base), 32'd32);
        check("s2_gap", 32'(last_gap), 32'd32);
        check_mosi("s2", 16'h0000);

        // Scenario 3: chnnl changes during TXN1
        start_conv(3'd2, 12'h3C1);
        repeat (100) @(negedge clk);
        chnnl = 3'd7;
        wait_done("s3");
        check_mosi("s3", 16'h1000);

        // Scenario 4: strt_cnv during GAP is ignored
        start_conv(3'd3, 12'h0F0);
        repeat (538) @(negedge clk);
        strt_cnv = 1'b1;
        @(negedge clk);
        strt_cnv = 1'b0;
`ifdef A2D_BUSY_ERR_EN
        check("s4_err", 32'(cnv_err), 32'd1);
`endif
        wait_done("s4");
        check_mosi("s4", 16'h1800);

        // Scenario 5: reset in the middle of TXN1
        start_conv(3'd6, 12'h777);
`ifdef A2D_BUSY_ERR_EN
        check("s5_err_clr", 32'(cnv_err), 32'd0);
`endif
        repeat (299) @(negedge clk);
        rst = 1'b1;
        #1;
        check("s5_ss_n", 32'(SS_n), 32'd1);
        check("s5_sclk", 32'(SCLK), 32'd1);
        check("s5_cmplt", 32'(cnv_cmplt), 32'd0);
        check("s5_res", 32'(res), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("s5_idle_ss_n", 32'(SS_n), 32'd1);
        start_conv(3'd1, 12'h9AB);
        wait_done("s5b");
        check_mosi("s5b", 16'h0800);

        // Scenario 6: restart from DONE, res holds until new completion
        start_conv(3'd4, 12'h123);
        wait_done("s6a");
        start_conv(3'd4, 12'h456);
        check("s6_cmplt_drop", 32'(cnv_cmplt), 32'd0);
        check("s6_res_hold", 32'(res), 32'h123);
        repeat (600) @(negedge clk);
        check("s6_res_mid", 32'(res), 32'h123);
        wait_done("s6b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
